// File: rtl/lutram_access_controller.sv
// Initiator-side front end for a single-port lutram.
// Clears every set after reset, then serves valid/ready read and write
// requests with byte-masked accesses. Read data returns on a held
// valid/ready response port.
module lutram_access_controller #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8,
  parameter int READ_LATENCY              = 1
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 request_valid_in,
  output logic                                 request_ready_out,
  input  logic                                 request_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
  input  logic [WRITE_MASK_LEN-1:0]            request_mask_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
  output logic                                 response_valid_out,
  input  logic                                 response_ready_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
  output logic                                 init_done_out,
  output logic                                 mem_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]            mem_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     mem_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_read_entry_in
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LATENCY - 1);

  // A byte mask only makes sense if every mask bit covers exactly one byte.
  if (WRITE_MASK_LEN * 8 != SINGLE_ENTRY_SIZE_IN_BITS) begin : g_mask_width_check
    $error("lutram_access_controller: WRITE_MASK_LEN*8 must equal SINGLE_ENTRY_SIZE_IN_BITS");
  end

  typedef enum logic [1:0] {INIT, IDLE, READ_WAIT, RESP} state_t;

  state_t                               state;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     sweep_cnt;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     rd_addr;
  logic [LAT_W-1:0]                     lat_cnt;
  logic                                 resp_valid;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_data;
  logic                                 init_done;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     hold_addr;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] hold_data;

  logic                                 ready_c;
  logic                                 access_c;
  logic [WRITE_MASK_LEN-1:0]            wen_c;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr_c;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_c;

  // Memory port and request-ready decode; IDLE writes pass straight through
  // so back-to-back writes run at one per cycle. Everything is forced low
  // while reset is asserted so no stray access reaches the lutram.
  always_comb begin
    ready_c  = 1'b0;
    access_c = 1'b0;
    wen_c    = '0;
    addr_c   = hold_addr;
    data_c   = hold_data;
    case (state)
      INIT: begin
        access_c = 1'b1;
        wen_c    = '1;
        addr_c   = sweep_cnt;
        data_c   = '0;
      end
      IDLE: begin
        ready_c = 1'b1;
        if (request_valid_in) begin
          access_c = 1'b1;
          addr_c   = request_addr_in;
          if (request_write_in) begin
            wen_c  = request_mask_in;
            data_c = request_data_in;
          end
        end
      end
      READ_WAIT: begin
        access_c = 1'b1;
        addr_c   = rd_addr;
      end
      default: ;
    endcase
    if (reset_in) begin
      ready_c  = 1'b0;
      access_c = 1'b0;
      wen_c    = '0;
      addr_c   = '0;
      data_c   = '0;
    end
  end

  assign request_ready_out   = ready_c;
  assign mem_access_en_out   = access_c;
  assign mem_write_en_out    = wen_c;
  assign mem_set_addr_out    = addr_c;
  assign mem_write_entry_out = data_c;
  assign response_valid_out  = resp_valid;
  assign response_data_out   = resp_data;
  assign init_done_out       = init_done;

  // Controller FSM: clear sweep, request accept, read latency count, response hold.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      rd_addr    <= '0;
      lat_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      init_done  <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
    end else begin
      hold_addr <= addr_c;
      hold_data <= data_c;
      case (state)
        INIT: begin
          if (sweep_cnt == LAST_SET) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (request_valid_in && !request_write_in) begin
            rd_addr <= request_addr_in;
            lat_cnt <= '0;
            state   <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (lat_cnt == LAST_LAT) begin
            resp_data  <= mem_read_entry_in;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          if (response_ready_in) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
